serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 117 +++++++++++
 tb/tb_serial_add_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: drives one external full-adder cell
// LSB first, WIDTH cycles per addition, registered sum and carry out.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_x,
  output logic             fa_y,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         state;
  state_t         nstate;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] nsr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             accept;

  assign last   = (cnt == CW'(WIDTH - 1));
  assign accept = (state == S_IDLE) && start;

  // Operand and carry registers drain to zero by the end of RUN,
  // so the adder inputs are quiet outside RUN without extra gating.
  assign fa_x   = ra[0];
  assign fa_y   = rb[0];
  assign fa_cin = carry;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          nstate = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (last) begin
          nstate = S_DONE;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        nstate = S_IDLE;
      end
      default: nstate = S_IDLE;
    endcase
  end

  always_comb begin
    nsr            = sr >> 1;
    nsr[WIDTH-1]   = fa_sum;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ra    <= '0;
      rb    <= '0;
      sr    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      ra    <= a;
      rb    <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == S_RUN) begin
      ra  <= ra >> 1;
      rb  <= rb >> 1;
      sr  <= nsr;
      cnt <= cnt + CW'(1);
      if (last) begin
        sum   <= nsr;
        cout  <= fa_cout;
        carry <= 1'b0;
      end else begin
        carry <= fa_cout;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: scoreboard on the 8-bit build plus a
// short directed sequence on a 1-bit build.
module tb_serial_add_ctrl;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic         start8 = 1'b0;
  logic [W-1:0] a8 = '0;
  logic [W-1:0] b8 = '0;
  logic         ci8 = 1'b0;
  logic         fx8, fy8, fc8, fs8, fco8;
  logic         busy8, done8, cout8;
  logic [W-1:0] sum8;

  logic start1 = 1'b0;
  logic a1 = 1'b0;
  logic b1 = 1'b0;
  logic ci1 = 1'b0;
  logic fx1, fy1, fc1, fs1, fco1;
  logic busy1, done1, cout1;
  logic sum1;

  exp_t q[$];
  int npass = 0;
  int ntot = 0;
  int cyc = 0;
  int bcnt = 0;
  bit mon_en = 0;
  logic [W-1:0] hold_s = '0;
  logic hold_c = 1'b0;

  always #5 clk = ~clk;

  assign fs8  = fx8 ^ fy8 ^ fc8;
  assign fco8 = (fx8 & fy8) | (fc8 & (fx8 ^ fy8));
  assign fs1  = fx1 ^ fy1 ^ fc1;
  assign fco1 = (fx1 & fy1) | (fc1 & (fx1 ^ fy1));

  serial_add_ctrl #(.WIDTH(W)) u8 (
    .clk(clk), .reset(reset), .start(start8),
    .a(a8), .b(b8), .cin(ci8),
    .fa_x(fx8), .fa_y(fy8), .fa_cin(fc8),
    .fa_sum(fs8), .fa_cout(fco8),
    .busy(busy8), .done(done8),
    .sum(sum8), .cout(cout8)
  );

  serial_add_ctrl #(.WIDTH(1)) u1 (
    .clk(clk), .reset(reset), .start(start1),
    .a(a1), .b(b1), .cin(ci1),
    .fa_x(fx1), .fa_y(fy1), .fa_cin(fc1),
    .fa_sum(fs1), .fa_cout(fco1),
    .busy(busy1), .done(done1),
    .sum(sum1), .cout(cout1)
  );

  task automatic chk(input string n, input longint act, input longint exp);
    ntot++;
    if (act == exp) begin
      npass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      hold_s = '0;
      hold_c = 1'b0;
      bcnt   = 0;
    end
  end

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (mon_en) begin
      if (done8) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sum", sum8, e.s);
          chk("cout", cout8, e.c);
          chk("latency", cyc - e.acc, W);
          chk("busy_cycles", bcnt, W);
        end
        bcnt   = 0;
        hold_s = sum8;
        hold_c = cout8;
      end else begin
        chk("result_hold", {cout8, sum8}, {hold_c, hold_s});
      end
      if (busy8) begin
        bcnt++;
      end else begin
        chk("fa_idle_zero", {fx8, fy8, fc8}, 0);
      end
    end
  end

  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y,
                    input logic c, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy8 || done8) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait_timeout", n < 100, 1);
    start8 = 1'b1;
    a8 = x;
    b8 = y;
    ci8 = c;
    if (push) begin
      logic [W:0] r;
      r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
      q.push_back('{s: r[W-1:0], c: r[W], acc: cyc + 1});
    end
    @(negedge clk);
    start8 = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_sum", sum8, 0);
    chk("rst_cout", cout8, 0);
    chk("rst_fa", {fx8, fy8, fc8}, 0);
    chk("rst_w1", {busy1, done1, sum1, cout1, fx1, fy1, fc1}, 0);
    reset = 1'b0;
    mon_en = 1;

    // 1-bit build: 1+1+1 = {1,1}
    start1 = 1'b1;
    a1 = 1'b1;
    b1 = 1'b1;
    ci1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("w1_busy", busy1, 1);
    chk("w1_fa", {fx1, fy1, fc1}, 3'b111);
    @(negedge clk);
    chk("w1_done", {done1, busy1}, 2'b10);
    chk("w1_result", {cout1, sum1}, 2'b11);
    @(negedge clk);
    chk("w1_done_clear", done1, 0);
    chk("w1_fa_idle", {fx1, fy1, fc1}, 0);

    op(8'h00, 8'h00, 1'b0, 1);
    op(8'h5A, 8'h35, 1'b0, 1);
    op(8'hFF, 8'h01, 1'b0, 1);

    // start re-pulsed mid-RUN must be ignored
    op(8'hFF, 8'hFF, 1'b1, 1);
    @(negedge clk);
    start8 = 1'b1;
    a8 = 8'h11;
    b8 = 8'h22;
    @(negedge clk);
    start8 = 1'b0;

    // reset in the 4th RUN cycle aborts the operation
    op(8'h77, 8'h11, 1'b0, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_sum", sum8, 0);
    chk("abort_cout", cout8, 0);
    reset = 1'b0;
    op(8'h12, 8'h34, 1'b0, 1);

    // start held high for 30 cycles: three launches, 10 cycles apart
    @(negedge clk);
    while (busy8 || done8) @(negedge clk);
    start8 = 1'b1;
    a8 = 8'h0F;
    b8 = 8'h01;
    ci8 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      q.push_back('{s: 8'h11, c: 1'b0, acc: cyc + 1 + 10 * k});
    end
    repeat (30) @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;

    for (int i = 0; i < 1000; i++) begin
      op(W'($urandom), W'($urandom), 1'($urandom), 1);
    end

    for (int n = 0; n < 200 && q.size() != 0; n++) begin
      @(negedge clk);
    end
    @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
